tdm_demux: RTL and testbench

- Receive end of the team's time-division mux link. It takes one word-serial stream carrying NCH channels in fixed slot order, with a start-of-frame marker on slot 0.
- It steers each word into a per-channel holding register and pulses that channel's valid strobe.
- It hunts for frame alignment, tracks slot position, and flags framing errors.
- It sits directly behind the link input, ahead of the per-channel consumers.

---
 rtl/tdm_pkg.sv | 14 +
 rtl/tdm_slot_ctr.sv | 28 ++
 rtl/tdm_demux.sv | 121 ++++++++++++
 tb/tb_tdm_demux.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link. The mux and demux both import these,
// so the two ends of the link use the same frame shape.
package tdm_pkg;

    localparam int NCH_DEF = 4;
    localparam int W_DEF   = 8;
    localparam int SW_DEF  = 2;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter for the TDM demux. Clear takes priority over load,
// and load takes priority over increment. The counter wraps after slot NCH-1.
module tdm_slot_ctr #(
    parameter int NCH = 4,
    parameter int SW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load1,
    input  logic          inc,
    output logic [SW-1:0] slot,
    output logic          last
);

    assign last = (slot == SW'(NCH - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SW'(1);
        end else if (inc) begin
            slot <= last ? '0 : slot + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Receive side of the TDM link. It hunts for a start-of-frame, then steers
// each slot into its own channel register and pulses that channel's strobe.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF,
    parameter int SW  = SW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    input  logic           in_sof,
    output logic [NCH*W-1:0] out_data,
    output logic [NCH-1:0] out_valid,
    output logic           frame_done,
    output logic           sync_err,
    output logic           locked
);

    tdm_state_t    state_q, state_d;
    logic [SW-1:0] slot;
    logic          last;
    logic          ctr_clear, ctr_load1, ctr_inc;
    logic          wr_en;
    logic [SW-1:0] wr_ch;
    logic          fdone_d, err_d;
    logic [NCH-1:0] strobe;

    tdm_slot_ctr #(
        .NCH (NCH),
        .SW  (SW)
    ) u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (ctr_clear),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .slot  (slot),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // An SOF always resyncs onto channel 0; only a missing SOF drops lock.
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_ch     = '0;
        ctr_clear = 1'b0;
        ctr_load1 = 1'b0;
        ctr_inc   = 1'b0;
        fdone_d   = 1'b0;
        err_d     = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        wr_en     = 1'b1;
                        ctr_load1 = 1'b1;
                        state_d   = LOCK;
                    end
                end
                LOCK: begin
                    if (in_sof) begin
                        wr_en     = 1'b1;
                        ctr_load1 = 1'b1;
                        err_d     = (slot != '0);
                    end else if (slot != '0) begin
                        wr_en   = 1'b1;
                        wr_ch   = slot;
                        ctr_inc = 1'b1;
                        fdone_d = last;
                    end else begin
                        err_d     = 1'b1;
                        ctr_clear = 1'b1;
                        state_d   = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        strobe = '0;
        for (int k = 0; k < NCH; k++) begin
            if (wr_en && (wr_ch == SW'(k))) begin
                strobe[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            out_valid  <= strobe;
            frame_done <= fdone_d;
            sync_err   <= err_d;
            for (int k = 0; k < NCH; k++) begin
                if (strobe[k]) begin
                    out_data[k*W +: W] <= in_data;
                end
            end
        end
    end

    assign locked = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed testbench for tdm_demux with NCH=4 and W=8. Each expected value
// is worked out by hand from the frame sequence that is driven.
module tb_tdm_demux;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_sof;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic        frame_done;
    logic        sync_err;
    logic        locked;

    int checks = 0;
    int errors = 0;

    tdm_demux #(
        .NCH (4),
        .W   (8),
        .SW  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 ns after the next rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic [3:0] v, input logic fd,
                              input logic err, input logic lk);
        checkOutput({tag, ".valid"}, {28'h0, out_valid}, {28'h0, v});
        checkOutput({tag, ".fdone"}, {31'h0, frame_done}, {31'h0, fd});
        checkOutput({tag, ".err"},   {31'h0, sync_err},   {31'h0, err});
        checkOutput({tag, ".lock"},  {31'h0, locked},     {31'h0, lk});
    endtask

    task automatic idleGaps(input string tag, input int n, input logic lk);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF);
            checkFlags(tag, 4'b0000, 1'b0, 1'b0, lk);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;

        // Reset state, with input activity that reset must override.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hEE);
        checkFlags("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.data", out_data, 32'h0000_0000);

        // Back-to-back frame.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h11);
        checkFlags("f1.w0", 4'b0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h22);
        checkFlags("f1.w1", 4'b0010, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h33);
        checkFlags("f1.w2", 4'b0100, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h44);
        checkFlags("f1.w3", 4'b1000, 1'b1, 1'b0, 1'b1);
        checkOutput("f1.data", out_data, 32'h4433_2211);
        idleGaps("f1.idle", 1, 1'b1);

        // HUNT drops non-SOF words silently.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hAA);
        checkFlags("hunt.aa", 4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hBB);
        checkFlags("hunt.bb", 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("hunt.data", out_data, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h11);
        checkFlags("hunt.sof", 4'b0001, 1'b0, 1'b0, 1'b1);

        // Early SOF at slot 2 resyncs onto channel 0.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h22);
        checkFlags("early.w1", 4'b0010, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h55);
        checkFlags("early.sof", 4'b0001, 1'b0, 1'b1, 1'b1);
        checkOutput("early.data", out_data, 32'h0000_2255);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h66);
        checkFlags("early.w1b", 4'b0010, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h77);
        checkFlags("early.w2", 4'b0100, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h88);
        checkFlags("early.w3", 4'b1000, 1'b1, 1'b0, 1'b1);
        checkOutput("early.data2", out_data, 32'h8877_6655);

        // Missing SOF after a complete frame drops lock and the word.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h99);
        checkFlags("miss", 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("miss.data", out_data, 32'h8877_6655);
        idleGaps("miss.idle", 1, 1'b0);

        // Frame with three idle cycles between words.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h11);
        checkFlags("gap.w0", 4'b0001, 1'b0, 1'b0, 1'b1);
        idleGaps("gap.i0", 3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h22);
        checkFlags("gap.w1", 4'b0010, 1'b0, 1'b0, 1'b1);
        idleGaps("gap.i1", 3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h33);
        checkFlags("gap.w2", 4'b0100, 1'b0, 1'b0, 1'b1);
        idleGaps("gap.i2", 3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h44);
        checkFlags("gap.w3", 4'b1000, 1'b1, 1'b0, 1'b1);
        checkOutput("gap.data", out_data, 32'h4433_2211);
        idleGaps("gap.i3", 3, 1'b1);

        // Reset mid-frame forgets slot position.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hA1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA2);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA3);
        checkOutput("mid.pre", out_data, 32'h44A3_A2A1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hEE);
        checkFlags("mid.rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("mid.rstdata", out_data, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
        checkFlags("mid.drop", 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("mid.dropdata", out_data, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C);
        checkFlags("mid.sof", 4'b0001, 1'b0, 1'b0, 1'b1);
        checkOutput("mid.sofdata", out_data, 32'h0000_003C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
